// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit period and the FSM state
// encoding common to the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned CPB_DEFAULT = 217;
  localparam int unsigned DATA_BITS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input; both flops reset to 1
// so a reset never looks like a falling edge to downstream logic.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises rx_serial, qualifies the start bit at mid-bit,
// then samples 8 data bits LSB-first and the stop bit, one sample per bit period.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned cpb = CPB_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic                 rx_dv,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_active,
  output logic                 rx_frame_err
);

  localparam logic [7:0] HALF_CNT = 8'((cpb - 1) / 2);
  localparam logic [7:0] LAST_CNT = 8'(cpb - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_sync;

  uart_sync2 u_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .async_i (rx_serial),
    .sync_o  (rx_sync)
  );

  uart_state_e          state_q, state_d;
  logic [7:0]           clk_count_q, clk_count_d;
  logic [2:0]           bit_index_q, bit_index_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_dv_q, rx_dv_d;
  logic                 rx_active_q, rx_active_d;
  logic                 rx_frame_err_q, rx_frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      clk_count_q    <= 8'd0;
      bit_index_q    <= 3'd0;
      data_q         <= '0;
      rx_data_q      <= '0;
      rx_dv_q        <= 1'b0;
      rx_active_q    <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clk_count_q    <= clk_count_d;
      bit_index_q    <= bit_index_d;
      data_q         <= data_d;
      rx_data_q      <= rx_data_d;
      rx_dv_q        <= rx_dv_d;
      rx_active_q    <= rx_active_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  // Strobes default low so each is high for exactly the cycle after the stop sample.
  always_comb begin
    state_d        = state_q;
    clk_count_d    = clk_count_q;
    bit_index_d    = bit_index_q;
    data_d         = data_q;
    rx_data_d      = rx_data_q;
    rx_active_d    = rx_active_q;
    rx_dv_d        = 1'b0;
    rx_frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_count_d = 8'd0;
        bit_index_d = 3'd0;
        if (!rx_sync) begin
          state_d     = ST_START;
          rx_active_d = 1'b1;
        end
      end

      ST_START: begin
        if (clk_count_q == HALF_CNT) begin
          clk_count_d = 8'd0;
          if (!rx_sync) begin
            state_d = ST_DATA;
          end else begin
            rx_active_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end else begin
          clk_count_d = clk_count_q + 8'd1;
        end
      end

      ST_DATA: begin
        if (clk_count_q < LAST_CNT) begin
          clk_count_d = clk_count_q + 8'd1;
        end else begin
          clk_count_d         = 8'd0;
          data_d[bit_index_q] = rx_sync;
          if (bit_index_q == LAST_BIT) begin
            bit_index_d = 3'd0;
            state_d     = ST_STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (clk_count_q < LAST_CNT) begin
          clk_count_d = clk_count_q + 8'd1;
        end else begin
          clk_count_d = 8'd0;
          rx_active_d = 1'b0;
          state_d     = ST_CLEANUP;
          if (rx_sync) begin
            rx_data_d = data_q;
            rx_dv_d   = 1'b1;
          end else begin
            rx_frame_err_d = 1'b1;
          end
        end
      end

      ST_CLEANUP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        clk_count_d = 8'd0;
        bit_index_d = 3'd0;
        rx_active_d = 1'b0;
      end
    endcase
  end

  assign rx_dv        = rx_dv_q;
  assign rx_data_out  = rx_data_q;
  assign rx_active    = rx_active_q;
  assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: a fast instance (8 clk/bit) for directed and random frames
// and a 217 clk/bit instance fed by a behavioural transmitter for loopback.
module tb_uart_rx_byte;

  localparam int CPB   = 8;
  localparam int CPB_L = 217;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rx_serial   = 1'b1;
  logic       rx_dv, rx_active, rx_frame_err;
  logic [7:0] rx_data_out;

  logic       rx_serial_l = 1'b1;
  logic       rx_dv_l, rx_active_l, rx_frame_err_l;
  logic [7:0] rx_data_out_l;

  uart_rx_byte #(.cpb(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (rx_serial),
    .rx_dv        (rx_dv),
    .rx_data_out  (rx_data_out),
    .rx_active    (rx_active),
    .rx_frame_err (rx_frame_err)
  );

  uart_rx_byte #(.cpb(CPB_L)) dut_l (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (rx_serial_l),
    .rx_dv        (rx_dv_l),
    .rx_data_out  (rx_data_out_l),
    .rx_active    (rx_active_l),
    .rx_frame_err (rx_frame_err_l)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  last_good = 8'h00;
  int          exp_dv = 0, exp_err = 0;
  int          dv_cnt = 0, err_cnt = 0;
  int          active_len = 0;
  int unsigned dv_cyc = 0, start_cyc = 0;
  logic        prev_dv = 1'b0, prev_err = 1'b0;

  logic [7:0]  lb_q[$];
  int unsigned lb_cyc_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame delivers its byte iff the stop bit is 1, else a frame error.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
      exp_dv++;
    end else begin
      exp_err++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_dv || rx_frame_err) check("dv_err_exclusive", rx_dv & rx_frame_err, 1'b0);
      if (rx_dv) begin
        dv_cnt++;
        dv_cyc = cyc;
        check("dv_width", prev_dv, 1'b0);
        check("dv_expected_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("dv_data", rx_data_out, exp_q.pop_front());
      end
      if (rx_frame_err) begin
        err_cnt++;
        check("err_width", prev_err, 1'b0);
      end
      if (rx_active) active_len++;
      if (rx_dv_l) begin
        lb_q.push_back(rx_data_out_l);
        lb_cyc_q.push_back(cyc);
      end
      if (rx_frame_err_l) check("lb_frame_err", rx_frame_err_l, 1'b0);
    end
    prev_dv  = rx_dv;
    prev_err = rx_frame_err;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) wait_clk();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_serial = 1'b0;
    start_cyc = cyc;
    repeat (CPB) wait_clk();
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) wait_clk();
    end
    rx_serial = stop;
    repeat (CPB) wait_clk();
    rx_serial = 1'b1;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_dv_cnt"}, dv_cnt, exp_dv);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_data"}, rx_data_out, last_good);
    check({tag, "_active"}, rx_active, 1'b0);
  endtask

  task automatic lb_send(input logic [7:0] b);
    int unsigned done_cyc;
    int unsigned got_cyc;
    int unsigned diff;
    rx_serial_l = 1'b0;
    repeat (CPB_L) wait_clk();
    for (int i = 0; i < 8; i++) begin
      rx_serial_l = b[i];
      repeat (CPB_L) wait_clk();
    end
    rx_serial_l = 1'b1;
    repeat (CPB_L) wait_clk();
    done_cyc = cyc;
    for (int i = 0; i < CPB_L && lb_q.size() == 0; i++) wait_clk();
    check("lb_dv_seen", lb_q.size(), 1);
    if (lb_q.size() > 0) begin
      check("lb_data", lb_q.pop_front(), b);
      got_cyc = lb_cyc_q.pop_front();
      diff = (got_cyc > done_cyc) ? got_cyc - done_cyc : done_cyc - got_cyc;
      check("lb_dv_near_done", diff <= CPB_L, 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int nominal;
    logic [7:0] rb;
    logic rs;

    rst = 1'b1;
    repeat (3) wait_clk();
    @(negedge clk);
    check("rst_dv", rx_dv, 1'b0);
    check("rst_data", rx_data_out, 8'h00);
    check("rst_active", rx_active, 1'b0);
    check("rst_err", rx_frame_err, 1'b0);
    check("rst_l_dv", rx_dv_l, 1'b0);
    check("rst_l_data", rx_data_out_l, 8'h00);
    rst = 1'b0;
    idle(5);

    // Single valid frame: data, latency and active window.
    model_frame(8'hA5, 1'b1);
    active_len = 0;
    send_byte(8'hA5, 1'b1);
    idle(20);
    check_idle_state("a5");
    lat = int'(dv_cyc - start_cyc);
    nominal = 2 + (CPB - 1) / 2 + 9 * CPB + 2;
    check("a5_latency", (lat >= nominal - 1) && (lat <= nominal + 1), 1'b1);
    check("a5_active_len", active_len, (CPB - 1) / 2 + 1 + 9 * CPB);

    // Short low glitch on an idle line.
    rx_serial = 1'b0;
    repeat (2) wait_clk();
    idle(30);
    check_idle_state("glitch");

    // Stop bit forced low, then a good frame.
    model_frame(8'h3C, 1'b0);
    send_byte(8'h3C, 1'b0);
    idle(20);
    check_idle_state("ferr");
    model_frame(8'h81, 1'b1);
    send_byte(8'h81, 1'b1);
    idle(20);
    check_idle_state("after_ferr");

    // Back-to-back frames with a single stop bit.
    model_frame(8'h00, 1'b1);
    model_frame(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(20);
    check_idle_state("b2b");

    // Reset in the middle of data bit 4 of 8'h5A.
    rx_serial = 1'b0;
    repeat (CPB) wait_clk();
    for (int i = 0; i < 4; i++) begin
      rx_serial = (8'h5A >> i) & 8'h01;
      repeat (CPB) wait_clk();
    end
    rx_serial = 1'b1;
    repeat (CPB / 2) wait_clk();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_dv", rx_dv, 1'b0);
    check("midrst_data", rx_data_out, 8'h00);
    check("midrst_active", rx_active, 1'b0);
    check("midrst_err", rx_frame_err, 1'b0);
    rst = 1'b0;
    last_good = 8'h00;
    idle(30);
    check_idle_state("midrst_idle");
    model_frame(8'hC3, 1'b1);
    send_byte(8'hC3, 1'b1);
    idle(20);
    check_idle_state("after_rst");

    // Random frames, mostly good, some with a bad stop bit.
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      model_frame(rb, rs);
      send_byte(rb, rs);
      idle($urandom_range(10, 30));
    end
    idle(20);
    check_idle_state("random");

    // Loopback against a behavioural transmitter at the default bit period.
    lb_send(8'h00);
    lb_send(8'h55);
    lb_send(8'hAA);
    lb_send(8'hFF);
    check("lb_data_out_final", rx_data_out_l, 8'hFF);

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
